cpu_mc: RTL

Parametrised successor core of the simple processor. It executes the same 32-bit instruction format and keeps the existing ALU, register file and PC datapath, generalised in data width and register count. It adds `bne`, shifts and load/store to a data memory with a BUSYWAIT stall handshake. It sits between the instruction memory (PC/INSTRUCTION) and a data memory or cache (READ/WRITE/ADDRESS/BUSYWAIT).

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/alu_w.sv | 40 ++++
 rtl/reg_file.sv | 36 +++
 rtl/cpu_mc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_mc core: opcode values, ALU operation
// selector and the two-state execute/memory-wait FSM encoding.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_BNE   = 8'd8;
  localparam logic [7:0] OP_LWD   = 8'd9;
  localparam logic [7:0] OP_LWI   = 8'd10;
  localparam logic [7:0] OP_SWD   = 8'd11;
  localparam logic [7:0] OP_SWI   = 8'd12;
  localparam logic [7:0] OP_SLL   = 8'd13;
  localparam logic [7:0] OP_SRL   = 8'd14;

  typedef enum logic [2:0] {
    ALU_FWD,
    ALU_ADD,
    ALU_AND,
    ALU_OR,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  typedef enum logic {
    ST_EXEC,
    ST_MEM_WAIT
  } state_e;

endpackage

// File: rtl/alu_w.sv
// W-bit ALU.
// Ports:
//   a_i, b_i  - operands (b is forwarded for FWD)
//   cin_i     - carry into the adder (1 with an inverted b gives subtract)
//   shamt_i   - shift amount for SLL/SRL
//   op_i      - operation select
//   result_o  - W-bit result, modulo 2^W
//   zero_o    - result == 0
module alu_w
  import cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  input  logic [4:0]   shamt_i,
  input  alu_op_e      op_i,
  output logic [W-1:0] result_o,
  output logic         zero_o
);

  // Shifts by W or more naturally produce zero because the result is
  // truncated to W bits.
  always_comb begin
    result_o = b_i;
    case (op_i)
      ALU_FWD: result_o = b_i;
      ALU_ADD: result_o = a_i + b_i + W'(cin_i);
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLL: result_o = a_i << shamt_i;
      ALU_SRL: result_o = a_i >> shamt_i;
      default: result_o = b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/reg_file.sv
// N x W register file, two combinational read ports, one write port.
// A write lands on the clock edge, so a same-cycle read sees the old value.
// Ports:
//   clk_i, rst_i         - clock, synchronous active-high reset (clears all)
//   we_i, waddr_i, wdata_i
//   raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o
module reg_file #(
  parameter int W = 8,
  parameter int N = 8,
  parameter int A = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [A-1:0] raddr_a_i,
  output logic [W-1:0] rdata_a_o,
  input  logic [A-1:0] raddr_b_i,
  output logic [W-1:0] rdata_b_o
);

  logic [W-1:0] regs_q [N];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle core, parametrised data width W and register count N.
// ALU and branch ops retire in one cycle; loads/stores issue a registered
// request to data memory and wait out MEM_BUSYWAIT.
//
// state       | meaning
// ST_EXEC     | decode and retire the instruction at PC, or issue a memory request
// ST_MEM_WAIT | request held on the memory port until MEM_BUSYWAIT drops
//
// Ports:
//   CLK, RESET                  - clock, synchronous active-high reset
//   INSTRUCTION, INSTR_BUSYWAIT - fetched word at PC, fetch-not-ready stall
//   PC                          - program counter
//   MEM_READ, MEM_WRITE         - registered data-memory requests
//   MEM_ADDRESS, MEM_WRITEDATA  - registered address / store data
//   MEM_READDATA, MEM_BUSYWAIT  - load data, memory busy
module cpu_mc
  import cpu_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  INSTRUCTION,
  input  logic         INSTR_BUSYWAIT,
  output logic [31:0]  PC,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [W-1:0] MEM_ADDRESS,
  output logic [W-1:0] MEM_WRITEDATA,
  input  logic [W-1:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam int A = $clog2(N);

  state_e       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic [W-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0] mem_wdata_q, mem_wdata_d;
  logic [A-1:0] ld_rd_q, ld_rd_d;

  logic [7:0]   opcode;
  logic [A-1:0] rd, rs1, rs2;
  logic [W-1:0] imm_ext;
  logic [31:0]  br_offset;
  logic [31:0]  pc_plus4;
  logic         unused_rs1_byte;

  logic [W-1:0] rs1_val, rs2_val;
  logic         rf_we;
  logic [A-1:0] rf_waddr;
  logic [W-1:0] rf_wdata;

  alu_op_e      alu_op;
  logic [W-1:0] alu_b, alu_result;
  logic         alu_cin, alu_zero;

  logic         wb_en, br_always, br_eq, br_ne, taken;
  logic         is_mem, is_load, addr_from_reg;

  assign opcode    = INSTRUCTION[31:24];
  assign rd        = INSTRUCTION[16 +: A];
  assign rs1       = INSTRUCTION[8 +: A];
  assign rs2       = INSTRUCTION[0 +: A];
  assign imm_ext   = W'($signed(INSTRUCTION[7:0]));
  assign br_offset = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
  assign pc_plus4  = pc_q + 32'd4;

  // Register-index bits above A in the rs1 byte are not decoded.
  assign unused_rs1_byte = ^INSTRUCTION[15:8];

  reg_file #(.W(W), .N(N), .A(A)) u_rf (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rs1),
    .rdata_a_o (rs1_val),
    .raddr_b_i (rs2),
    .rdata_b_o (rs2_val)
  );

  alu_w #(.W(W)) u_alu (
    .a_i      (rs1_val),
    .b_i      (alu_b),
    .cin_i    (alu_cin),
    .shamt_i  (INSTRUCTION[4:0]),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_comb begin
    alu_op        = ALU_FWD;
    alu_b         = imm_ext;
    alu_cin       = 1'b0;
    wb_en         = 1'b0;
    br_always     = 1'b0;
    br_eq         = 1'b0;
    br_ne         = 1'b0;
    is_mem        = 1'b0;
    is_load       = 1'b0;
    addr_from_reg = 1'b0;
    case (opcode)
      OP_LOADI: wb_en = 1'b1;
      OP_MOV: begin
        alu_b = rs2_val;
        wb_en = 1'b1;
      end
      OP_ADD: begin
        alu_op = ALU_ADD;
        alu_b  = rs2_val;
        wb_en  = 1'b1;
      end
      OP_SUB: begin
        alu_op  = ALU_ADD;
        alu_b   = ~rs2_val;
        alu_cin = 1'b1;
        wb_en   = 1'b1;
      end
      OP_AND: begin
        alu_op = ALU_AND;
        alu_b  = rs2_val;
        wb_en  = 1'b1;
      end
      OP_OR: begin
        alu_op = ALU_OR;
        alu_b  = rs2_val;
        wb_en  = 1'b1;
      end
      OP_J: br_always = 1'b1;
      OP_BEQ, OP_BNE: begin
        alu_op  = ALU_ADD;
        alu_b   = ~rs2_val;
        alu_cin = 1'b1;
        br_eq   = (opcode == OP_BEQ);
        br_ne   = (opcode == OP_BNE);
      end
      OP_LWD: begin
        is_mem        = 1'b1;
        is_load       = 1'b1;
        addr_from_reg = 1'b1;
      end
      OP_LWI: begin
        is_mem  = 1'b1;
        is_load = 1'b1;
      end
      OP_SWD: begin
        is_mem        = 1'b1;
        addr_from_reg = 1'b1;
      end
      OP_SWI: is_mem = 1'b1;
      OP_SLL: begin
        alu_op = ALU_SLL;
        wb_en  = 1'b1;
      end
      OP_SRL: begin
        alu_op = ALU_SRL;
        wb_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign taken = br_always | (br_eq & alu_zero) | (br_ne & ~alu_zero);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_rd_d     = ld_rd_q;
    rf_we       = 1'b0;
    rf_waddr    = rd;
    rf_wdata    = alu_result;
    case (state_q)
      ST_EXEC: begin
        if (!INSTR_BUSYWAIT) begin
          if (is_mem) begin
            mem_addr_d  = addr_from_reg ? rs2_val : imm_ext;
            mem_wdata_d = rs1_val;
            mem_read_d  = is_load;
            mem_write_d = ~is_load;
            // rd is latched because INSTRUCTION may change during the wait.
            ld_rd_d     = rd;
            state_d     = ST_MEM_WAIT;
          end else begin
            rf_we = wb_en;
            pc_d  = taken ? (pc_plus4 + br_offset) : pc_plus4;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          rf_we       = mem_read_q;
          rf_waddr    = ld_rd_q;
          rf_wdata    = MEM_READDATA;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          pc_d        = pc_plus4;
          state_d     = ST_EXEC;
        end
      end
      default: state_d = ST_EXEC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_EXEC;
      pc_q        <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_rd_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_rd_q     <= ld_rd_d;
    end
  end

  assign PC            = pc_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

endmodule
